// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier between two clients.
// Grants in IDLE, pulses start/ack in ISSUE, then tracks the multiplier through BUSY and RUN.
module mul_arbiter #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0,
   input  logic           req1,
   input  logic [N-1:0]   a0,
   input  logic [N-1:0]   b0,
   input  logic [N-1:0]   a1,
   input  logic [N-1:0]   b1,
   input  logic           signed0,
   input  logic           signed1,
   output logic           ack0,
   output logic           ack1,
   output logic           done0,
   output logic           done1,
   output logic [2*N-1:0] res0,
   output logic [2*N-1:0] res1,
   output logic           busy,
   output logic           mul_start,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   output logic           mul_signed,
   input  logic           mul_ready,
   input  logic [2*N-1:0] mul_product,
   output logic [1:0]     dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic           owner_q, owner_d;
   logic           prio_q, prio_d;
   logic [N-1:0]   mul_a_q, mul_a_d;
   logic [N-1:0]   mul_b_q, mul_b_d;
   logic           mul_signed_q, mul_signed_d;
   logic [2*N-1:0] res0_q, res0_d;
   logic [2*N-1:0] res1_q, res1_d;
   logic           done0_q, done0_d;
   logic           done1_q, done1_d;
   logic           winner;

   // Client handshake: req is a level held until ack; ack pulses once when the
   // operands are captured; done pulses once when res is updated.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      prio_d       = prio_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      mul_signed_d = mul_signed_q;
      res0_d       = res0_q;
      res1_d       = res1_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      winner       = (req0 && req1) ? prio_q : req1;
      case (state_q)
         IDLE: begin
            if (mul_ready && (req0 || req1)) begin
               owner_d      = winner;
               prio_d       = ~winner;
               mul_a_d      = winner ? a1 : a0;
               mul_b_d      = winner ? b1 : b0;
               mul_signed_d = winner ? signed1 : signed0;
               state_d      = ISSUE;
            end
         end
         ISSUE: state_d = BUSY;
         BUSY: begin
            // The multiplier dropping ready is the only proof it took the start.
            if (!mul_ready) state_d = RUN;
         end
         RUN: begin
            if (mul_ready) begin
               if (owner_q) begin
                  res1_d  = mul_product;
                  done1_d = 1'b1;
               end else begin
                  res0_d  = mul_product;
                  done0_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         prio_q       <= 1'b0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         mul_signed_q <= 1'b0;
         res0_q       <= '0;
         res1_q       <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         prio_q       <= prio_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         mul_signed_q <= mul_signed_d;
         res0_q       <= res0_d;
         res1_q       <= res1_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
      end
   end

   assign ack0       = (state_q == ISSUE) && !owner_q;
   assign ack1       = (state_q == ISSUE) && owner_q;
   assign mul_start  = (state_q == ISSUE);
   assign busy       = (state_q != IDLE);
   assign done0      = done0_q;
   assign done1      = done1_q;
   assign res0       = res0_q;
   assign res1       = res1_q;
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign mul_signed = mul_signed_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Arbiter and sequencer that shares one sequential shift-add multiplier between two requesters. It sits between two client ports and the multiplier's start/ready/product interface, with the multiplier's `load`/`shift`/`addshift`/`sub` control internal to the multiplier. Each client gets an operand-capture handshake and a result-return pulse, and contention is resolved round-robin. The block owns `mul_start` and steers operands and product to and from the granted client.

## Interface
- `N`, 4: operand width. Product width is 2N.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0). The multiplier is reset from the same net, inverted at top level.
- `req0`, `req1`  in  1  client request, level. Held high until the matching `ack` is seen.
- `a0`, `b0`, `a1`, `b1`  in  N  client operands. Valid while `req` is high.
- `signed0`, `signed1`  in  1  client signed-multiply flag. Valid while `req` is high.
- `ack0`, `ack1`  out  1  one-cycle pulse: operands captured, and the client may drop `req`.
- `done0`, `done1`  out  1  one-cycle pulse: `res` is valid.
- `res0`, `res1`  out  2N  per-client result register. Holds its value until that client's next completion.
- `busy`  out  1  high in any state other than IDLE.
- `mul_start`  out  1  start pulse to the multiplier.
- `mul_a`, `mul_b`  out  N  registered operands to the multiplier.
- `mul_signed`  out  1  registered signed flag to the multiplier.
- `mul_ready`  in  1  multiplier idle/ready.
- `mul_product`  in  2N  multiplier result.

## Operation
- The FSM has four states: IDLE, ISSUE, BUSY, RUN. It records `owner` (1 bit) and round-robin pointer `prio` (1 bit).
- **IDLE**
  - Requires `mul_ready`=1 and at least one `req` high to grant.
  - With a single request, that requester wins.
  - With both requesting, the requester indexed by `prio` wins.
  - On grant: `owner` <= winner, `prio` <= ~winner, `mul_a`/`mul_b`/`mul_signed` <= winner's inputs, next state ISSUE.
  - `mul_ready`=0 blocks any grant; the FSM stays in IDLE.
- **ISSUE** lasts one cycle. Outputs `mul_start`=1 and `ack[owner]`=1 (Moore). Next state BUSY.
- **BUSY** waits for `mul_ready`=0, meaning the multiplier has accepted the start. Then next state RUN.
- **RUN** waits for `mul_ready`=1. On that edge: `res[owner]` <= `mul_product`, `done[owner]` <= 1 (registered, one-cycle pulse), next state IDLE.
- Requests are sampled only in IDLE. `req` edges in any other state are ignored.
  - A `req` still high when IDLE is re-entered counts as a new request.
- Widths: operands pass through unmodified. The product is captured full 2N bits with no truncation. Sign handling belongs to the multiplier.
- Outputs in each state:
  - `mul_a`/`mul_b`/`mul_signed` are stable from ISSUE through RUN.
  - `res` of the non-owner never changes.
  - `ack` and `done` are never high for both clients in the same cycle.

## Timing
- Reset values: state=IDLE, `owner`=0, `prio`=0 (client 0 favoured). All outputs are 0, including `res0`/`res1`, `mul_a`/`mul_b`, `mul_signed`, `busy`, `mul_start`, `ack`, `done`.
- Reset asserted mid-operation aborts immediately to the reset values.
  - No `done` is issued for the aborted operation.
  - Releasing reset resumes in IDLE.
- Latency with the multiplier taking N cycles in its run state:
  - `req` sampled at edge t0 gives ISSUE (`ack`, `mul_start`) in cycle t1.
  - BUSY in t2, then RUN from t3.
  - The multiplier returns `mul_ready` in cycle t2+N.
  - `done` is high in cycle t2+N+1.
  - For N=4, `done` is high 7 cycles after the grant edge.
- Back-to-back: the `done` cycle is an IDLE cycle and may grant the next request. The next `ack` then follows one cycle after `done`.
- A `done` pulse and a new grant evaluation in the same IDLE cycle are both legal.
- BUSY has no timeout; a multiplier that never drops `mul_ready` stalls the arbiter, and this is by design.

## Test plan
- **Single unsigned request:** `req0`=1, `a0`=3, `b0`=5, `signed0`=0.
  - `ack0` is a pulse 1 cycle after the grant edge.
  - `done0` comes 7 cycles after the grant edge with `res0`=8'd15.
  - `res1` stays 0.
- **Signed request:** `req1`=1, `a1`=4'hD (-3), `b1`=4'h2, `signed1`=1. Requires `done1` with `res1`=8'hFA (-6) and `mul_signed`=1 from ISSUE through RUN.
- **Simultaneous requests, twice in a row:** `req0` and `req1` high together after reset.
  - Client 0 is served first, then client 1 granted in the `done0` cycle.
  - When both are re-raised, client 0 wins again (`prio` has returned to 0).
  - `ack`/`done` are never concurrent.
- **Multiplier not ready:** hold `mul_ready`=0 with `req0`=1 for 5 cycles. No `ack0` and `busy`=0 during that time; the grant comes on the first edge with `mul_ready`=1.
- **Reset mid-operation:** assert `reset`=0 during RUN.
  - All outputs read 0 within the same cycle.
  - No `done` appears after release.
  - A fresh request (`a0`=7, `b0`=7) completes with `res0`=8'd49.
- **Hold-over request:** keep `req0` high through `done0`. A second `ack0` is required one cycle after `done0`, with the operands re-captured from the current `a0`/`b0`.
